instr_issuer: RTL and testbench
===============================

INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 SHALL have ports: clk input 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset input 1, synchronous, active-high reset.
REQ-003 SHALL have port: wr_en input 1, program-memory write strobe.
REQ-004 SHALL have port: wr_addr input 4, program-memory write address.
REQ-005 SHALL have port: wr_data input 16, instruction word to store.
REQ-006 SHALL have port: start input 1, request to execute the stored program.
REQ-007 SHALL have port: count input 5, number of instructions to issue, 0..16.
REQ-008 SHALL have port: done input 1, instruction-complete from the control unit.
REQ-009 SHALL have port: instruction output 16, word presented to the control unit, [15:13] is destination register.
REQ-010 SHALL have port: run output 1, one-cycle issue pulse.
REQ-011 SHALL have port: pc output 4, index of the instruction currently presented.
REQ-012 SHALL have port: busy output 1, high from start acceptance until program end.
REQ-013 SHALL have port: finished output 1, one-cycle pulse at program end.
REQ-014 SHALL have port: error output 1, sticky timeout flag.

Function
REQ-015 SHALL hold a 16 x 16-bit program memory, written when wr_en=1 and busy=0; writes while busy=1 ignored.
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, FINISH; all outputs registered.
REQ-017 IDLE: start=1 and count!=0 accepted -> pc<=0, instruction<=mem[0], busy<=1, go ISSUE next cycle; start with count=0 ignored.
REQ-018 count>16 SHALL be clamped to 16; count latched at acceptance, later changes ignored.
REQ-019 ISSUE: run=1 for exactly one cycle, then WAIT; instruction SHALL stay stable from ISSUE until leaving WAIT.
REQ-020 WAIT: run=0; done=1 and pc==latched_count-1 -> FINISH; done=1 otherwise -> pc<=pc+1, instruction<=mem[pc+1], ISSUE.
REQ-021 done SHALL be honored only in WAIT; done in IDLE, ISSUE, FINISH ignored.
REQ-022 FINISH: finished=1 one cycle, busy<=0, go IDLE; pc and instruction hold last values.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 Latency: start accepted at cycle N -> run=1 at N+1; done at cycle M in WAIT -> next run=1 at M+1 or finished=1 at M+1.
REQ-025 pc SHALL never wrap; max value 15 with count=16.

Reset
REQ-026 reset=1 SHALL force IDLE, instruction=0, run=0, pc=0, busy=0, finished=0, error=0, timeout counter=0, mid-program included.
REQ-027 reset SHALL NOT clear program memory contents.
REQ-028 reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-029 Macro ISSUE_TIMEOUT_EN defined: 8-bit counter runs in WAIT, cleared on entering WAIT; reaching 255 without done -> error<=1, busy<=0, go IDLE, no finished pulse.
REQ-030 With ISSUE_TIMEOUT_EN: error sticky until reset or next accepted start (cleared at acceptance).
REQ-031 Macro undefined: WAIT waits indefinitely, no counter logic, error tied to 0.

Verification
REQ-032 Load mem[0..2]=0x2000,0x4000,0x6000, count=3, start, done 2 cycles after each run -> three run pulses with instruction 0x2000,0x4000,0x6000, pc 0,1,2, finished once, busy low after.
REQ-033 count=0 with start=1 -> no run, busy stays 0; count=20 -> exactly 16 run pulses, pc reaches 15, no wrap.
REQ-034 wr_en to addr 1 with 0xFFFF while busy, then rerun -> mem[1] unchanged; done pulse during ISSUE -> ignored, FSM stays waiting in WAIT.
REQ-035 reset asserted in WAIT at pc=1 -> next cycle all outputs zero, state IDLE; new start reissues from pc=0 with preserved memory.
REQ-036 ISSUE_TIMEOUT_EN defined, withhold done -> error=1 and busy=0 after 255 WAIT cycles, no finished; next start clears error.
REQ-037 start held high through FINISH -> new program accepted only in IDLE, run one cycle after acceptance.

Source files
------------

// File: rtl/instr_issuer.sv
// -----------------------------------------------------------------------------
// instr_issuer
//
// Holds a 16-entry program of 16-bit instruction words and hands them to a
// control unit one at a time. After an accepted start, each word is presented
// on `instruction` together with a one-cycle `run` pulse. The next word is
// issued only after the control unit answers with `done`.
//
// Ports
//   clk          in   sole clock; all state updates on the rising edge
//   reset        in   synchronous, active-high; leaves program memory intact
//   wr_en        in   program-memory write strobe (ignored while busy)
//   wr_addr[3:0] in   program-memory write address
//   wr_data[15:0]in   instruction word to store
//   start        in   request to run the stored program (ignored while busy)
//   count[4:0]   in   number of instructions to issue, 0..16 (larger -> 16)
//   done         in   instruction-complete from the control unit
//   instruction  out  word presented to the control unit ([15:13] = dest reg)
//   run          out  one-cycle issue pulse
//   pc[3:0]      out  index of the word currently presented
//   busy         out  high from start acceptance until program end
//   finished     out  one-cycle pulse at normal program end
//   error        out  sticky timeout flag
//
// Configuration
//   ISSUE_TIMEOUT_EN  when defined, an 8-bit watchdog runs in WAIT. If 255
//                     WAIT cycles pass without done, the program is abandoned:
//                     error is set, busy drops and no finished pulse is given.
//                     When undefined, WAIT waits forever and error is 0.
// -----------------------------------------------------------------------------
module instr_issuer (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        start,
  input  logic [4:0]  count,
  input  logic        done,
  output logic [15:0] instruction,
  output logic        run,
  output logic [3:0]  pc,
  output logic        busy,
  output logic        finished,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t      state;
  logic [15:0] mem [16];
  logic [3:0]  last_pc;   // index of the final word of the accepted program
  logic [3:0]  pc_inc;

`ifdef ISSUE_TIMEOUT_EN
  logic [7:0]  tmo_cnt;
`endif

  assign pc_inc = pc + 4'd1;

  // NOTE: program memory has no reset so a reset mid-program keeps the loaded
  // program; this also lets synthesis map it onto plain RAM/register-file
  // cells. Reset still wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: every register below is updated with non-blocking assignments so
  // all outputs change together at the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instruction <= '0;
      run         <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      last_pc     <= '0;
`ifdef ISSUE_TIMEOUT_EN
      error       <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      // Pulses default low; only the transitions below raise them.
      run      <= 1'b0;
      finished <= 1'b0;

      case (state)
        IDLE: begin
          if (start && count != 5'd0) begin
            pc          <= '0;
            instruction <= mem[0];
            busy        <= 1'b1;
            run         <= 1'b1;
            // Clamp to 16 words: count of 16 or more ends at index 15.
            last_pc     <= (count >= 5'd16) ? 4'd15 : count[3:0] - 4'd1;
            state       <= ISSUE;
`ifdef ISSUE_TIMEOUT_EN
            error       <= 1'b0;
`endif
          end
        end

        ISSUE: begin
          state <= WAIT;
`ifdef ISSUE_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end

        WAIT: begin
          if (done) begin
            if (pc == last_pc) begin
              finished <= 1'b1;
              state    <= FINISH;
            end else begin
              pc          <= pc_inc;
              instruction <= mem[pc_inc];
              run         <= 1'b1;
              state       <= ISSUE;
            end
          end
`ifdef ISSUE_TIMEOUT_EN
          // Counter would reach 255 this edge: this was the 255th WAIT cycle.
          else if (tmo_cnt == 8'd254) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef ISSUE_TIMEOUT_EN
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issuer.sv
// -----------------------------------------------------------------------------
// tb_instr_issuer
//
// Self-checking bench for instr_issuer. Expected (pc, instruction) pairs are
// queued from a local memory model whenever a program is launched, and a
// negedge monitor pops one per run pulse. The main thread acts as the control
// unit and checks reset state, latency, clamping, ignored writes/done/start,
// and reset mid-program. Define ISSUE_TIMEOUT_EN to also check the watchdog.
// -----------------------------------------------------------------------------
module tb_instr_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [4:0]  count;
  logic        done;
  logic [15:0] instruction;
  logic        run;
  logic [3:0]  pc;
  logic        busy;
  logic        finished;
  logic        error;

  always #5 clk = ~clk;

  instr_issuer dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .count       (count),
    .done        (done),
    .instruction (instruction),
    .run         (run),
    .pc          (pc),
    .busy        (busy),
    .finished    (finished),
    .error       (error)
  );

  typedef struct packed {
    logic [3:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp_item;
  logic [15:0] model_mem [16];
  int          vectors     = 0;
  int          miscompares = 0;
  int          fin_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Scoreboard consumer: one expected entry per issue pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (run) begin
        if (exp_q.size() == 0) begin
          check("unexpected_run", 32'd1, 32'd0);
        end else begin
          exp_item = exp_q.pop_front();
          check("run_pc", {28'd0, pc}, {28'd0, exp_item.pc});
          check("run_instr", {16'd0, instruction}, {16'd0, exp_item.instr});
        end
      end
      if (finished) fin_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [15:0] d,
                           input bit commit);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (commit) model_mem[a] = d;
  endtask

  // Pulse start for one cycle; returns at the negedge of the cycle after.
  task automatic launch(input logic [4:0] c);
    int n;
    n = (c > 5'd16) ? 16 : int'(c);
    for (int i = 0; i < n; i++) exp_q.push_back('{pc: 4'(i), instr: model_mem[i]});
    count = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    count = 5'($urandom_range(0, 31));   // must not affect the latched count
    @(negedge clk);
    if (n > 0) begin
      check("lat_run", {31'd0, run}, 32'd1);
      check("lat_busy", {31'd0, busy}, 32'd1);
    end else begin
      check("zero_run", {31'd0, run}, 32'd0);
      check("zero_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic pulse_done(input int gap);
    repeat (gap) @(posedge clk);
    #1 done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    @(negedge clk);
    for (int k = 0; k < 30 && !run; k++) @(negedge clk);
    if (!run) check({tag, "_run_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_fin(input string tag);
    @(negedge clk);
    for (int k = 0; k < 30 && !finished; k++) @(negedge clk);
    if (!finished) check({tag, "_fin_timeout"}, 32'd0, 32'd1);
  endtask

  // Act as the control unit for n issues; the first run is already showing.
  task automatic serve(input int n, input int gap, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i > 0) wait_run(tag);
      pulse_done(gap);
    end
    wait_fin(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int          f0;
    int          k;
    logic [15:0] d;

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; count = '0; done = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_instr", {16'd0, instruction}, 32'd0);
    check("rst_run", {31'd0, run}, 32'd0);
    check("rst_pc", {28'd0, pc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_finished", {31'd0, finished}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);

    // Load program: first three words are 0x2000, 0x4000, 0x6000.
    for (int i = 0; i < 16; i++) begin
      if (i < 3) d = 16'((i + 1) * 16'h2000);
      else       d = {3'(i), 13'(i * 131 + 7)};
      write_mem(4'(i), d, 1'b1);
    end

    // Three-word program, done two cycles after each run.
    f0 = fin_cnt;
    launch(5'd3);
    serve(3, 2, "p3");
    check("p3_fin_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("p3_busy_low", {31'd0, busy}, 32'd0);
    check("p3_fin_once", 32'(fin_cnt - f0), 32'd1);
    check("p3_q_empty", 32'(exp_q.size()), 32'd0);
    check("p3_pc_hold", {28'd0, pc}, 32'd2);
    check("p3_instr_hold", {16'd0, instruction}, 32'h6000);

    // count = 0 is ignored.
    launch(5'd0);
    repeat (3) tick();
    @(negedge clk);
    check("zero_stays_idle", {31'd0, busy}, 32'd0);

    // count = 20 clamps to 16 issues, pc stops at 15.
    f0 = fin_cnt;
    launch(5'd20);
    serve(16, 1, "p16");
    check("p16_q_empty", 32'(exp_q.size()), 32'd0);
    check("p16_pc_max", {28'd0, pc}, 32'd15);
    check("p16_instr", {16'd0, instruction}, {16'd0, model_mem[15]});
    @(negedge clk);
    check("p16_fin_once", 32'(fin_cnt - f0), 32'd1);

    // Write while busy and done during ISSUE are both ignored.
    launch(5'd2);
    done = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'hFFFF;
    @(posedge clk);
    #1 done = 1'b0; wr_en = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("issue_done_busy", {31'd0, busy}, 32'd1);
    check("issue_done_pc", {28'd0, pc}, 32'd0);
    pulse_done(1);
    wait_run("p2");
    pulse_done(1);
    wait_fin("p2");
    tick();
    launch(5'd2);
    serve(2, 1, "p2b");
    tick();

    // Reset in WAIT at pc = 1 with competing inputs; memory survives.
    launch(5'd4);
    pulse_done(1);
    wait_run("rstw");
    tick();
    reset = 1'b1; start = 1'b1; count = 5'd3; done = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; done = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_instr", {16'd0, instruction}, 32'd0);
    check("mid_rst_run", {31'd0, run}, 32'd0);
    check("mid_rst_pc", {28'd0, pc}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_fin", {31'd0, finished}, 32'd0);
    launch(5'd3);
    serve(3, 1, "post_rst");
    tick();

    // start held high through FINISH: re-accepted only from IDLE.
    f0 = fin_cnt;
    for (int i = 0; i < 2; i++) exp_q.push_back('{pc: 4'd0, instr: model_mem[0]});
    count = 5'd1;
    start = 1'b1;
    wait_run("hold");
    pulse_done(1);
    wait_fin("hold");
    check("hold_fin_norun", {31'd0, run}, 32'd0);
    @(negedge clk);
    check("hold_idle_busy", {31'd0, busy}, 32'd0);
    check("hold_idle_run", {31'd0, run}, 32'd0);
    @(negedge clk);
    check("hold_reaccept_run", {31'd0, run}, 32'd1);
    start = 1'b0;
    pulse_done(1);
    wait_fin("hold2");
    @(negedge clk);
    check("hold_fin_twice", 32'(fin_cnt - f0), 32'd2);
    check("hold_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef ISSUE_TIMEOUT_EN
    // Withhold done: error after 255 WAIT cycles, no finished pulse.
    tick();
    f0 = fin_cnt;
    launch(5'd1);
    k = 0;
    while (!error && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cycles", 32'(k), 32'd256);
    check("tmo_error", {31'd0, error}, 32'd1);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_no_fin", 32'(fin_cnt - f0), 32'd0);
    tick();
    launch(5'd1);
    check("tmo_err_cleared", {31'd0, error}, 32'd0);
    serve(1, 1, "tmo_rerun");
`else
    k = 0;
    check("err_tied_low", {31'd0, error}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
